pipe_stage_chain: RTL and testbench



---
 rtl/pipe_stage_chain.sv | 120 ++++++++++++
 tb/tb_pipe_stage_chain.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid/allow_in pipeline registers with per-stage stall,
// younger-stage flush, exported stage state, occupancy and input-stall counter.
module pipe_stage_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_allow_in,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_allow_in,
  input  logic [DEPTH-1:0]       ready_go,
  input  logic                   flush,
  input  logic [SW-1:0]          flush_stage,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CW-1:0]          occupancy,
  output logic [31:0]            stall_cnt
);

  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [31:0]      stallCnt_q, stallCnt_d;

  logic [DEPTH:0]   allow;
  logic [DEPTH-1:0] srcV;
  logic [WIDTH-1:0] srcD [DEPTH];
  logic [SW-1:0]    flushIdx;

  // Back-pressure ripples combinationally from the consumer down to stage 0.
  always_comb begin
    allow        = '0;
    allow[DEPTH] = out_allow_in;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      allow[k] = !valid_q[k] || (ready_go[k] && allow[k+1]);
    end
  end

  always_comb begin
    srcV    = '0;
    srcV[0] = in_valid;
    srcD[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      srcV[k] = valid_q[k-1] && ready_go[k-1];
      srcD[k] = data_q[k-1];
    end
  end

  assign flushIdx = (flush_stage > LAST) ? LAST : flush_stage;

  // The redirecting stage itself empties if it can move on; everything younger dies.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = data_q[k];
      if (allow[k]) begin
        valid_d[k] = srcV[k];
        if (srcV[k]) begin
          data_d[k] = srcD[k];
        end
      end
      if (flush) begin
        if (k < int'(flushIdx)) begin
          valid_d[k] = 1'b0;
        end else if ((k == int'(flushIdx)) && allow[k]) begin
          valid_d[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (in_valid && !allow[0] && !flush && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      stallCnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      stallCnt_q <= stallCnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CW'(valid_q[k]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stageData
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign in_allow_in = allow[0];
  assign out_valid   = valid_q[DEPTH-1] && ready_go[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus a randomized run checked
// against an in-order accept/deliver scoreboard.
module tb_pipe_stage_chain;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int SW    = 2;
  localparam int CW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   inValid;
  logic [WIDTH-1:0]       inData;
  logic                   inAllowIn;
  logic                   outValid;
  logic [WIDTH-1:0]       outData;
  logic                   outAllowIn;
  logic [DEPTH-1:0]       readyGo;
  logic                   flush;
  logic [SW-1:0]          flushStage;
  logic [DEPTH-1:0]       stageValid;
  logic [DEPTH*WIDTH-1:0] stageData;
  logic [CW-1:0]          occupancy;
  logic [31:0]            stallCnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] accQ [$];
  int               accCyc [$];
  logic [WIDTH-1:0] outQ [$];
  int               outCyc [$];

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (inValid),
    .in_data      (inData),
    .in_allow_in  (inAllowIn),
    .out_valid    (outValid),
    .out_data     (outData),
    .out_allow_in (outAllowIn),
    .ready_go     (readyGo),
    .flush        (flush),
    .flush_stage  (flushStage),
    .stage_valid  (stageValid),
    .stage_data   (stageData),
    .occupancy    (occupancy),
    .stall_cnt    (stallCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Logs every handshake seen at the negedge, then advances past the next rising edge.
  task automatic cycleObs();
    @(negedge clk);
    if (!reset && inValid && inAllowIn && !flush) begin
      accQ.push_back(inData);
      accCyc.push_back(cyc);
    end
    if (!reset && outValid && outAllowIn) begin
      outQ.push_back(outData);
      outCyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleInputs();
    inValid    = 1'b0;
    inData     = '0;
    outAllowIn = 1'b1;
    readyGo    = '1;
    flush      = 1'b0;
    flushStage = '0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    accQ.delete();
    accCyc.delete();
    outQ.delete();
    outCyc.delete();
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++;
    if (inAllowIn !== 1'b1) begin failures++; $display("[TB] FAIL reset_allow got=%b exp=1", inAllowIn); end
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid); end
    checks++;
    if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++;
    if (stallCnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_stall_cnt got=%0d exp=0", stallCnt); end
    checks++;
    if (stageValid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_stage_valid got=%b exp=0000", stageValid); end
  endtask

  task automatic test_streaming();
    doReset();
    for (int i = 0; i < 9; i++) begin
      inValid = (i < 3);
      inData  = WIDTH'(i + 1);
      cycleObs();
    end
    inValid = 1'b0;
    checks++;
    if (outQ.size() != 3) begin failures++; $display("[TB] FAIL stream_count got=%0d exp=3", outQ.size()); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (j >= outQ.size() || j >= accQ.size()) begin
        failures++; $display("[TB] FAIL stream_missing[%0d] got=absent exp=%0d", j, j + 1);
      end else begin
        if (outQ[j] !== WIDTH'(j + 1)) begin failures++; $display("[TB] FAIL stream_data[%0d] got=%h exp=%h", j, outQ[j], j + 1); end
        checks++;
        if (outCyc[j] - accCyc[j] != DEPTH) begin
          failures++; $display("[TB] FAIL stream_latency[%0d] got=%0d exp=%0d", j, outCyc[j] - accCyc[j], DEPTH);
        end
        checks++;
        if (outCyc[j] != accCyc[0] + DEPTH + j) begin
          failures++; $display("[TB] FAIL stream_cycle[%0d] got=%0d exp=%0d", j, outCyc[j], accCyc[0] + DEPTH + j);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    doReset();
    outAllowIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inData  = WIDTH'(64'hA + i);
      cycleObs();
    end
    inData = 64'hE;
    #1;
    checks++;
    if (occupancy !== 3'd4) begin failures++; $display("[TB] FAIL bp_occupancy got=%0d exp=4", occupancy); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (inAllowIn !== 1'b0) begin failures++; $display("[TB] FAIL bp_allow[%0d] got=%b exp=0", i, inAllowIn); end
      cycleObs();
    end
    inValid = 1'b0;
    #1;
    checks++;
    if (stallCnt !== 32'd5) begin failures++; $display("[TB] FAIL bp_stall_cnt got=%0d exp=5", stallCnt); end
    checks++;
    if (accQ.size() != 4) begin failures++; $display("[TB] FAIL bp_accepted got=%0d exp=4", accQ.size()); end
    outAllowIn = 1'b1;
    for (int i = 0; i < 6; i++) cycleObs();
    checks++;
    if (outQ.size() != 4) begin failures++; $display("[TB] FAIL bp_drain_count got=%0d exp=4", outQ.size()); end
    for (int j = 0; j < 4 && j < outQ.size(); j++) begin
      checks++;
      if (outQ[j] !== WIDTH'(64'hA + j)) begin failures++; $display("[TB] FAIL bp_order[%0d] got=%h exp=%h", j, outQ[j], 64'hA + j); end
    end
  endtask

  task automatic test_mid_stall();
    int bubbles = 0;
    doReset();
    for (int i = 0; i < 15; i++) begin
      readyGo = (i >= 5 && i < 8) ? 4'b1011 : 4'b1111;
      inValid = (i < 11);
      inData  = WIDTH'(accQ.size() + 1);
      #1;
      if (i >= 4 && !outValid) bubbles++;
      if (i == 6) begin
        checks++;
        if (stageValid[2] !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold got=%b exp=1", stageValid[2]); end
      end
      cycleObs();
    end
    idleInputs();
    for (int i = 0; i < 5; i++) cycleObs();
    checks++;
    if (bubbles != 3) begin failures++; $display("[TB] FAIL stall_bubbles got=%0d exp=3", bubbles); end
    checks++;
    if (accQ.size() != 8) begin failures++; $display("[TB] FAIL stall_accepted got=%0d exp=8", accQ.size()); end
    checks++;
    if (outQ.size() != accQ.size()) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=%0d", outQ.size(), accQ.size()); end
    for (int j = 0; j < outQ.size(); j++) begin
      checks++;
      if (outQ[j] !== WIDTH'(j + 1)) begin failures++; $display("[TB] FAIL stall_order[%0d] got=%h exp=%h", j, outQ[j], j + 1); end
    end
  endtask

  task automatic test_flush();
    doReset();
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inData  = WIDTH'(64'h10 + i);
      cycleObs();
    end
    flush      = 1'b1;
    flushStage = 2'd2;
    inData     = 64'h99;
    #1;
    checks++;
    if (inAllowIn !== 1'b1) begin failures++; $display("[TB] FAIL flush_allow got=%b exp=1", inAllowIn); end
    cycleObs();
    idleInputs();
    #1;
    checks++;
    if (stageValid !== 4'b1000) begin failures++; $display("[TB] FAIL flush_stage_valid got=%b exp=1000", stageValid); end
    checks++;
    if (stageData[3*WIDTH +: WIDTH] !== 64'h11) begin
      failures++; $display("[TB] FAIL flush_stage_data got=%h exp=11", stageData[3*WIDTH +: WIDTH]);
    end
    checks++;
    if (occupancy !== 3'd1) begin failures++; $display("[TB] FAIL flush_occupancy got=%0d exp=1", occupancy); end
    for (int i = 0; i < 5; i++) cycleObs();
    checks++;
    if (outQ.size() != 2) begin failures++; $display("[TB] FAIL flush_out_count got=%0d exp=2", outQ.size()); end
    else begin
      checks++;
      if (outQ[0] !== 64'h10 || outQ[1] !== 64'h11) begin
        failures++; $display("[TB] FAIL flush_out_data got=%h,%h exp=10,11", outQ[0], outQ[1]);
      end
    end

    // Oldest stage as the redirect point while blocked: it holds, all younger die.
    doReset();
    outAllowIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inData  = WIDTH'(64'h20 + i);
      cycleObs();
    end
    flush      = 1'b1;
    flushStage = 2'd3;
    cycleObs();
    flush   = 1'b0;
    inValid = 1'b0;
    #1;
    checks++;
    if (stageValid !== 4'b1000) begin failures++; $display("[TB] FAIL flush3_stage_valid got=%b exp=1000", stageValid); end
    checks++;
    if (stageData[3*WIDTH +: WIDTH] !== 64'h20) begin
      failures++; $display("[TB] FAIL flush3_stage_data got=%h exp=20", stageData[3*WIDTH +: WIDTH]);
    end
    checks++;
    if (stallCnt !== 32'd0) begin failures++; $display("[TB] FAIL flush3_stall_cnt got=%0d exp=0", stallCnt); end
  endtask

  task automatic test_random();
    int  stallExp = 0;
    int  inflight;
    bit  allRg;
    logic expAllow;
    doReset();
    for (int i = 0; i < 400; i++) begin
      inValid    = ($urandom_range(0, 9) < 7);
      inData     = {$urandom, $urandom};
      outAllowIn = ($urandom_range(0, 3) != 0);
      allRg      = ($urandom_range(0, 3) != 0);
      readyGo    = allRg ? 4'b1111 : 4'($urandom);
      #1;
      inflight = accQ.size() - outQ.size();
      checks++;
      if (occupancy !== CW'(inflight)) begin failures++; $display("[TB] FAIL rnd_occupancy@%0d got=%0d exp=%0d", i, occupancy, inflight); end
      if (allRg) begin
        expAllow = !(inflight == DEPTH && !outAllowIn);
        checks++;
        if (inAllowIn !== expAllow) begin failures++; $display("[TB] FAIL rnd_allow@%0d got=%b exp=%b", i, inAllowIn, expAllow); end
        if (inValid && !expAllow) stallExp++;
      end else if (inValid && !inAllowIn) begin
        stallExp++;
      end
      cycleObs();
    end
    idleInputs();
    for (int i = 0; i < 8; i++) cycleObs();
    checks++;
    if (stallCnt !== 32'(stallExp)) begin failures++; $display("[TB] FAIL rnd_stall_cnt got=%0d exp=%0d", stallCnt, stallExp); end
    checks++;
    if (outQ.size() != accQ.size()) begin failures++; $display("[TB] FAIL rnd_count got=%0d exp=%0d", outQ.size(), accQ.size()); end
    for (int j = 0; j < outQ.size() && j < accQ.size(); j++) begin
      checks++;
      if (outQ[j] !== accQ[j]) begin failures++; $display("[TB] FAIL rnd_order[%0d] got=%h exp=%h", j, outQ[j], accQ[j]); end
    end
  endtask

  task automatic test_saturation_priority();
    longint expCnt;
    doReset();
    outAllowIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inData  = WIDTH'(64'h30 + i);
      cycleObs();
    end
    force dut.stallCnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stallCnt_q;
    for (int n = 1; n <= 5; n++) begin
      cycleObs();
      expCnt = 64'hFFFF_FFFD + n;
      if (expCnt > 64'hFFFF_FFFF) expCnt = 64'hFFFF_FFFF;
      checks++;
      if (stallCnt !== 32'(expCnt)) begin failures++; $display("[TB] FAIL sat_cnt[%0d] got=%h exp=%h", n, stallCnt, 32'(expCnt)); end
    end
    reset      = 1'b1;
    flush      = 1'b1;
    flushStage = 2'd1;
    inValid    = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    flush   = 1'b0;
    inValid = 1'b0;
    #1;
    checks++;
    if (stageValid !== 4'b0000) begin failures++; $display("[TB] FAIL prio_stage_valid got=%b exp=0000", stageValid); end
    checks++;
    if (stallCnt !== 32'd0) begin failures++; $display("[TB] FAIL prio_stall_cnt got=%h exp=0", stallCnt); end
    checks++;
    if (stageData !== '0) begin failures++; $display("[TB] FAIL prio_stage_data got=%h exp=0", stageData); end
    checks++;
    if (inAllowIn !== 1'b1 || outValid !== 1'b0 || occupancy !== 3'd0) begin
      failures++; $display("[TB] FAIL prio_outputs got=allow%b/valid%b/occ%0d exp=allow1/valid0/occ0", inAllowIn, outValid, occupancy);
    end
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_mid_stall();
    test_flush();
    test_random();
    test_saturation_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
